// File: rtl/axis_insert_header_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_insert_header_pkg
// Description : Shared state encoding and byte-count/mask helpers for the
//               AXI-Stream header inserter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_insert_header_pkg;

   localparam int MAX_BYTES = 64;

   typedef logic [7:0]           bcnt_t;
   typedef logic [MAX_BYTES-1:0] bmask_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   // A zero byte count encodes a full-width word
   function automatic bcnt_t cnt_to_bytes(input bcnt_t cnt, input bcnt_t w);
      return (cnt == 8'd0) ? w : cnt;
   endfunction

   function automatic bmask_t count_to_keep_msb(input bcnt_t n, input bcnt_t w);
      bmask_t m;
      m = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if ((bcnt_t'(i) < w) && ((bcnt_t'(i) + n) >= w)) m[i] = 1'b1;
      end
      return m;
   endfunction

   function automatic bcnt_t popcount(input bmask_t m);
      bcnt_t c;
      c = '0;
      for (int i = 0; i < MAX_BYTES; i++) c = c + {7'd0, m[i]};
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axis_hdr_byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : axis_hdr_byte_merge
// Description : Combinational merge of MSB-aligned residual bytes with the
//               valid bytes of an incoming beat; splits into output word and
//               new residual.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_hdr_byte_merge
   import axis_insert_header_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8
) (
   input  logic [DATA_WD-1:0]      residual,
   input  bcnt_t                   res_cnt,
   input  logic [DATA_WD-1:0]      data_in,
   input  bcnt_t                   data_cnt,
   output logic [DATA_WD-1:0]      merged,
   output logic [DATA_BYTE_WD-1:0] merged_keep,
   output logic [DATA_WD-1:0]      new_residual,
   output bcnt_t                   new_cnt,
   output logic                    overflow
);

   localparam bcnt_t W_B = bcnt_t'(DATA_BYTE_WD);

   logic [DATA_BYTE_WD-1:0] data_mask;
   logic [DATA_WD-1:0]      data_masked;
   logic [2*DATA_WD-1:0]    joined;
   logic [15:0]             shift_bits;
   bcnt_t                   total;

   always_comb begin
      data_mask   = DATA_BYTE_WD'(count_to_keep_msb(data_cnt, W_B));
      data_masked = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         data_masked[i*8 +: 8] = data_mask[i] ? data_in[i*8 +: 8] : 8'd0;
      end
      // Input MSB lands directly below the R residual bytes in a 2W-byte window
      shift_bits   = {5'd0, bcnt_t'(W_B - res_cnt), 3'd0};
      joined       = {residual, {DATA_WD{1'b0}}} |
                     ({{DATA_WD{1'b0}}, data_masked} << shift_bits);
      total        = res_cnt + data_cnt;
      overflow     = total > W_B;
      new_cnt      = overflow ? bcnt_t'(total - W_B) : 8'd0;
      merged_keep  = DATA_BYTE_WD'(count_to_keep_msb(overflow ? W_B : total, W_B));
      merged       = joined[2*DATA_WD-1 -: DATA_WD];
      new_residual = joined[DATA_WD-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/axis_insert_header.sv
`default_nettype none
// ============================================================================
// Module      : axis_insert_header
// Description : Prepends a per-packet header of N bytes to an AXI-Stream
//               packet and repacks the result into full-width beats.
//               Optional macro AXIS_INSERT_HEADER_CHECK_EN adds a sticky
//               proto_err output for malformed keep/count inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_insert_header
   import axis_insert_header_pkg::*;
#(
   parameter int DATA_WD      = 32,
   parameter int DATA_BYTE_WD = DATA_WD / 8,
   parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    ready_in,
   output logic                    valid_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    ready_out,
   input  logic                    valid_insert,
   input  logic [DATA_WD-1:0]      data_insert,
   input  logic [DATA_BYTE_WD-1:0] keep_insert,
   input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
`ifdef AXIS_INSERT_HEADER_CHECK_EN
   output logic                    ready_insert,
   output logic                    proto_err
`else
   output logic                    ready_insert
`endif
);

   localparam bcnt_t W_B = bcnt_t'(DATA_BYTE_WD);

   state_t                  state_q, state_d;
   logic [DATA_WD-1:0]      residual_q, residual_d;
   bcnt_t                   res_cnt_q, res_cnt_d;
   logic                    valid_out_q, valid_out_d;
   logic [DATA_WD-1:0]      data_out_q, data_out_d;
   logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
   logic                    last_out_q, last_out_d;

   bcnt_t                   hdr_n;
   bcnt_t                   data_cnt;
   logic [DATA_WD-1:0]      hdr_masked;
   logic [DATA_WD-1:0]      hdr_aligned;
   logic                    out_free;

   logic [DATA_WD-1:0]      merged;
   logic [DATA_BYTE_WD-1:0] merged_keep;
   logic [DATA_WD-1:0]      new_residual;
   bcnt_t                   new_cnt;
   logic                    overflow;

   axis_hdr_byte_merge #(
      .DATA_WD      (DATA_WD),
      .DATA_BYTE_WD (DATA_BYTE_WD)
   ) u_merge (
      .residual     (residual_q),
      .res_cnt      (res_cnt_q),
      .data_in      (data_in),
      .data_cnt     (data_cnt),
      .merged       (merged),
      .merged_keep  (merged_keep),
      .new_residual (new_residual),
      .new_cnt      (new_cnt),
      .overflow     (overflow)
   );

   // Header bytes sit in the low N lanes; move them to the MSB side
   always_comb begin
      hdr_n      = cnt_to_bytes(bcnt_t'(byte_insert_cnt), W_B);
      data_cnt   = popcount(bmask_t'(keep_in));
      hdr_masked = '0;
      for (int i = 0; i < DATA_BYTE_WD; i++) begin
         if (bcnt_t'(i) < hdr_n) hdr_masked[i*8 +: 8] = data_insert[i*8 +: 8];
      end
      hdr_aligned = hdr_masked << {5'd0, bcnt_t'(W_B - hdr_n), 3'd0};
      out_free    = !valid_out_q || ready_out;
   end

   always_comb begin
      state_d      = state_q;
      residual_d   = residual_q;
      res_cnt_d    = res_cnt_q;
      valid_out_d  = valid_out_q && !ready_out;
      data_out_d   = data_out_q;
      keep_out_d   = keep_out_q;
      last_out_d   = last_out_q;
      ready_in     = 1'b0;
      ready_insert = 1'b0;
      case (state_q)
         IDLE: begin
            ready_insert = !rst;
            if (valid_insert && ready_insert) begin
               residual_d = hdr_aligned;
               res_cnt_d  = hdr_n;
               state_d    = DATA;
            end
         end
         DATA: begin
            ready_in = !rst && out_free;
            if (valid_in && ready_in) begin
               valid_out_d = 1'b1;
               data_out_d  = merged;
               keep_out_d  = merged_keep;
               last_out_d  = last_in && !overflow;
               residual_d  = new_residual;
               res_cnt_d   = new_cnt;
               if (last_in) state_d = overflow ? TAIL : IDLE;
            end
         end
         TAIL: begin
            if (out_free) begin
               valid_out_d = 1'b1;
               data_out_d  = residual_q;
               keep_out_d  = DATA_BYTE_WD'(count_to_keep_msb(res_cnt_q, W_B));
               last_out_d  = 1'b1;
               residual_d  = '0;
               res_cnt_d   = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         residual_q  <= '0;
         res_cnt_q   <= '0;
         valid_out_q <= 1'b0;
         data_out_q  <= '0;
         keep_out_q  <= '0;
         last_out_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         residual_q  <= residual_d;
         res_cnt_q   <= res_cnt_d;
         valid_out_q <= valid_out_d;
         data_out_q  <= data_out_d;
         keep_out_q  <= keep_out_d;
         last_out_q  <= last_out_d;
      end
   end

   assign valid_out = valid_out_q;
   assign data_out  = data_out_q;
   assign keep_out  = keep_out_q;
   assign last_out  = last_out_q;

`ifdef AXIS_INSERT_HEADER_CHECK_EN
   logic proto_err_q, proto_err_d;
   logic hdr_bad, keep_gap, keep_short;

   always_comb begin
      hdr_bad     = popcount(bmask_t'(keep_insert)) != hdr_n;
      keep_gap    = keep_in != DATA_BYTE_WD'(count_to_keep_msb(data_cnt, W_B));
      keep_short  = !last_in && (keep_in != '1);
      proto_err_d = proto_err_q
                  | (valid_insert && ready_insert && hdr_bad)
                  | (valid_in && ready_in && (keep_gap || keep_short));
   end

   always_ff @(posedge clk) begin
      if (rst) proto_err_q <= 1'b0;
      else     proto_err_q <= proto_err_d;
   end

   assign proto_err = proto_err_q;
`else
   logic unused_keep_insert;
   assign unused_keep_insert = ^keep_insert;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_insert_header.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_insert_header
// Description : Scoreboard bench for axis_insert_header: packet-level byte
//               stream model, directed and random packets, mid-packet reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_insert_header;

   localparam int DW = 32;
   localparam int W  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid_in, last_in, ready_in;
   logic [DW-1:0] data_in;
   logic [W-1:0]  keep_in;
   logic          valid_out, last_out, ready_out;
   logic [DW-1:0] data_out;
   logic [W-1:0]  keep_out;
   logic          valid_insert, ready_insert;
   logic [DW-1:0] data_insert;
   logic [W-1:0]  keep_insert;
   logic [1:0]    byte_insert_cnt;

   always #5 clk = ~clk;

   axis_insert_header #(.DATA_WD(DW)) dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .ready_in        (ready_in),
      .valid_out       (valid_out),
      .data_out        (data_out),
      .keep_out        (keep_out),
      .last_out        (last_out),
      .ready_out       (ready_out),
      .valid_insert    (valid_insert),
      .data_insert     (data_insert),
      .keep_insert     (keep_insert),
      .byte_insert_cnt (byte_insert_cnt),
      .ready_insert    (ready_insert)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [W-1:0]  keep;
      logic          last;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] pkt_bytes[$];
   int         checks = 0;
   int         errors = 0;
   logic       mon_en = 1'b0;
   int         rdy_mode = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Downstream ready: 0 always ready, 1 random, 2 held low
   initial begin
      ready_out = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       ready_out = 1'b1;
            1:       ready_out = ($urandom_range(0, 99) < 60);
            default: ready_out = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each output handshake
   initial begin
      beat_t prev;
      beat_t e;
      logic  prev_stall;
      prev_stall = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (prev_stall)
               check("hold", {31'd0, valid_out, data_out, keep_out, last_out},
                             {31'd0, 1'b1, prev});
            if (valid_out && !ready_out)
               check("ready_in_stall", {63'd0, ready_in}, 64'd0);
            if (valid_out && ready_out) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_beat: got %h/%b/%b expected none", data_out, keep_out, last_out);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", {27'd0, data_out, keep_out, last_out}, {27'd0, e});
               end
            end
            prev_stall = valid_out && !ready_out;
            prev       = {data_out, keep_out, last_out};
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic push_beat(input logic [DW-1:0] d, input logic [W-1:0] k, input logic l);
      exp_q.push_back({d, k, l});
   endtask

   // Reference: header bytes (most significant valid byte first) then payload, chunked by W
   task automatic push_model(input logic [DW-1:0] hdr, input int n);
      logic [7:0] s[$];
      beat_t      e;
      for (int k = n - 1; k >= 0; k--) s.push_back(hdr[8*k +: 8]);
      foreach (pkt_bytes[i]) s.push_back(pkt_bytes[i]);
      while (s.size() > 0) begin
         e = '0;
         for (int b = 0; b < W && s.size() > 0; b++) begin
            e.data[DW-1-8*b -: 8] = s.pop_front();
            e.keep[W-1-b]         = 1'b1;
         end
         e.last = (s.size() == 0);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_hs(input int which, input string name);
      int  t;
      logic r;
      t = 0;
      forever begin
         @(negedge clk);
         r = (which == 0) ? ready_insert : ready_in;
         @(posedge clk); #1;
         if (r) break;
         t++;
         if (t > 500) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no handshake expected handshake", name);
            break;
         end
      end
   endtask

   task automatic send_hdr(input logic [DW-1:0] hdr, input int n);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      valid_insert    = 1'b1;
      data_insert     = hdr;
      byte_insert_cnt = 2'(n % W);
      keep_insert     = 4'((1 << n) - 1);
      wait_hs(0, "hdr");
      valid_insert    = 1'b0;
      data_insert     = $urandom;
   endtask

   task automatic send_data();
      int            idx;
      int            m;
      logic [DW-1:0] d;
      logic [W-1:0]  k;
      idx = 0;
      while (idx < pkt_bytes.size()) begin
         m = (pkt_bytes.size() - idx >= W) ? W : pkt_bytes.size() - idx;
         d = $urandom;
         k = '0;
         for (int b = 0; b < m; b++) begin
            d[DW-1-8*b -: 8] = pkt_bytes[idx+b];
            k[W-1-b]         = 1'b1;
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         valid_in = 1'b1;
         data_in  = d;
         keep_in  = k;
         last_in  = (idx + m == pkt_bytes.size());
         wait_hs(1, "data");
         valid_in = 1'b0;
         idx      = idx + m;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] hdr;
      int            n;
      int            len;
      rst = 1'b1;
      valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
      valid_insert = 1'b0; data_insert = '0; keep_insert = '0; byte_insert_cnt = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {24'd0, valid_out, data_out, keep_out, last_out, ready_in, ready_insert}, 64'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Directed cases with literal expectations
      pkt_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
      push_beat(32'hAABB1122, 4'b1111, 1'b0);
      push_beat(32'h33445566, 4'b1111, 1'b0);
      push_beat(32'h778899AA, 4'b1111, 1'b1);
      send_hdr(32'h0000AABB, 2);
      send_data();

      pkt_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      push_beat(32'hAABBCC11, 4'b1111, 1'b0);
      push_beat(32'h22334400, 4'b1110, 1'b1);
      send_hdr(32'h00AABBCC, 3);
      send_data();

      pkt_bytes = '{8'h12, 8'h34};
      push_beat(32'hDEADBEEF, 4'b1111, 1'b0);
      push_beat(32'h12340000, 4'b1100, 1'b1);
      send_hdr(32'hDEADBEEF, 4);
      send_data();

      pkt_bytes = '{8'h55};
      push_beat(32'hAA550000, 4'b1100, 1'b1);
      send_hdr(32'h000000AA, 1);
      send_data();
      drain();

      // Random packets with random downstream backpressure
      rdy_mode = 1;
      for (int p = 0; p < 100; p++) begin
         hdr = $urandom;
         n   = $urandom_range(1, W);
         len = $urandom_range(1, 13);
         pkt_bytes.delete();
         for (int i = 0; i < len; i++) pkt_bytes.push_back(8'($urandom));
         push_model(hdr, n);
         send_hdr(hdr, n);
         send_data();
      end
      drain();

      // Reset in the middle of a packet with an output beat stalled
      mon_en   = 1'b0;
      rdy_mode = 2;
      @(posedge clk); #1;
      pkt_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_hdr(32'h00000077, 1);
      valid_in = 1'b1; data_in = 32'h01020304; keep_in = 4'b1111; last_in = 1'b0;
      wait_hs(1, "rst_data");
      valid_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_reset_outputs", {24'd0, valid_out, data_out, keep_out, last_out, ready_in, ready_insert}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_insert_after_rst", {63'd0, ready_insert}, 64'd1);
      @(posedge clk); #1;
      exp_q.delete();
      mon_en   = 1'b1;
      rdy_mode = 1;
      pkt_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      push_beat(32'hAABBCC11, 4'b1111, 1'b0);
      push_beat(32'h22334400, 4'b1110, 1'b1);
      send_hdr(32'h00AABBCC, 3);
      send_data();
      drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
